// File: rtl/xmit_arbiter.sv
// Round-robin arbiter that serialises sample words and meta bytes onto the single-byte transmitter.
// Optional XMIT_QUERY_ID_EN adds a query_id strobe that sends the "1ALS" ID string with top priority.
module xmit_arbiter #(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic        clock,
  input  logic        extReset,
  input  logic        sample_write,
  input  logic [31:0] sample_data,
  input  logic [3:0]  disabledGroups,
  output logic        sample_idle,
  input  logic        meta_write,
  input  logic [7:0]  meta_byte,
  output logic        meta_idle,
`ifdef XMIT_QUERY_ID_EN
  input  logic        query_id,
`endif
  input  logic        tx_busy,
  output logic        tx_write,
  output logic [7:0]  tx_byte,
  output logic        xmit_idle
);

  localparam int unsigned GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP, WAITTX} state_t;
  typedef enum logic [1:0] {SRC_SAMPLE, SRC_META, SRC_ID} src_t;

  state_t        state, state_n;
  src_t          src, src_n, last_grant, last_n;
  logic [1:0]    idx, idx_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic          sample_pend, sample_pend_n, sample_clr;
  logic          meta_pend, meta_pend_n, meta_clr;
  logic [31:0]   sample_word;
  logic [3:0]    sample_mask;
  logic [7:0]    meta_q;
  logic          tx_write_n, xmit_idle_n;
  logic [7:0]    tx_byte_n;
  logic [2:0]    first_en, after_en;
  logic          id_busy_n;
`ifdef XMIT_QUERY_ID_EN
  logic          id_pend, id_pend_n, id_clr;
`endif

  // Lowest enabled group at or above 'from'; 4 means none left.
  function automatic logic [2:0] find_en(input logic [3:0] dis, input logic [2:0] from);
    logic [2:0] r;
    r = 3'd4;
    for (int unsigned g = 0; g < 4; g++) begin
      if (r == 3'd4 && 3'(g) >= from && !dis[g]) r = 3'(g);
    end
    return r;
  endfunction

  assign first_en    = find_en(sample_mask, 3'd0);
  assign after_en    = find_en(sample_mask, {1'b0, idx} + 3'd1);
  assign sample_idle = ~sample_pend;
  assign meta_idle   = ~meta_pend;

  always_ff @(posedge clock) begin
    if (extReset) begin
      state       <= IDLE;
      src         <= SRC_SAMPLE;
      last_grant  <= SRC_SAMPLE;
      idx         <= '0;
      gap_cnt     <= '0;
      sample_pend <= 1'b0;
      meta_pend   <= 1'b0;
`ifdef XMIT_QUERY_ID_EN
      id_pend     <= 1'b0;
`endif
      tx_write    <= 1'b0;
      tx_byte     <= '0;
      xmit_idle   <= 1'b1;
    end else begin
      state       <= state_n;
      src         <= src_n;
      last_grant  <= last_n;
      idx         <= idx_n;
      gap_cnt     <= gap_n;
      sample_pend <= sample_pend_n;
      meta_pend   <= meta_pend_n;
`ifdef XMIT_QUERY_ID_EN
      id_pend     <= id_pend_n;
`endif
      tx_write    <= tx_write_n;
      tx_byte     <= tx_byte_n;
      xmit_idle   <= xmit_idle_n;
    end
  end

  // Payload registers only load while the matching request slot is free.
  always_ff @(posedge clock) begin
    if (sample_write && !sample_pend) begin
      sample_word <= sample_data;
      sample_mask <= disabledGroups;
    end
    if (meta_write && !meta_pend) meta_q <= meta_byte;
  end

  always_comb begin
    state_n    = state;
    src_n      = src;
    idx_n      = idx;
    last_n     = last_grant;
    gap_n      = gap_cnt;
    sample_clr = 1'b0;
    meta_clr   = 1'b0;
`ifdef XMIT_QUERY_ID_EN
    id_clr     = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef XMIT_QUERY_ID_EN
        if (id_pend) begin
          src_n   = SRC_ID;
          idx_n   = '0;
          state_n = SEND;
        end else
`endif
        if (sample_pend && (!meta_pend || last_grant == SRC_META)) begin
          last_n = SRC_SAMPLE;
          src_n  = SRC_SAMPLE;
          // A fully masked word is consumed here without touching the transmitter.
          if (first_en[2]) begin
            sample_clr = 1'b1;
          end else begin
            idx_n   = first_en[1:0];
            state_n = SEND;
          end
        end else if (meta_pend) begin
          last_n  = SRC_META;
          src_n   = SRC_META;
          idx_n   = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        gap_n   = GAP_LOAD;
        state_n = GAP;
        case (src)
          SRC_META:   meta_clr   = 1'b1;
          SRC_SAMPLE: sample_clr = after_en[2];
`ifdef XMIT_QUERY_ID_EN
          SRC_ID:     id_clr     = (idx == 2'd3);
`endif
          default: ;
        endcase
      end
      GAP: begin
        if (gap_cnt == '0) state_n = WAITTX;
        else               gap_n   = gap_cnt - GW'(1);
      end
      WAITTX: begin
        if (!tx_busy) begin
          if (src == SRC_SAMPLE && !after_en[2]) begin
            idx_n   = after_en[1:0];
            state_n = SEND;
          end
`ifdef XMIT_QUERY_ID_EN
          else if (src == SRC_ID && idx != 2'd3) begin
            idx_n   = idx + 2'd1;
            state_n = SEND;
          end
`endif
          else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    sample_pend_n = sample_pend ? !sample_clr : sample_write;
    meta_pend_n   = meta_pend ? !meta_clr : meta_write;
`ifdef XMIT_QUERY_ID_EN
    id_pend_n     = id_pend ? !id_clr : query_id;
    id_busy_n     = id_pend_n;
`else
    id_busy_n     = 1'b0;
`endif
  end

  // Outputs are computed from next-state values so they emerge registered.
  always_comb begin
    tx_write_n  = (state_n == SEND);
    tx_byte_n   = tx_byte;
    if (state_n == SEND) begin
      case (src_n)
        SRC_SAMPLE: tx_byte_n = sample_word[{idx_n, 3'b000} +: 8];
        SRC_META:   tx_byte_n = meta_q;
`ifdef XMIT_QUERY_ID_EN
        SRC_ID: begin
          case (idx_n)
            2'd0:    tx_byte_n = 8'h31;
            2'd1:    tx_byte_n = 8'h41;
            2'd2:    tx_byte_n = 8'h4C;
            default: tx_byte_n = 8'h53;
          endcase
        end
`endif
        default: ;
      endcase
    end
    xmit_idle_n = (state_n == IDLE) && !sample_pend_n && !meta_pend_n && !id_busy_n;
  end

endmodule

// File: tb/tb_xmit_arbiter.sv
// Directed bench for xmit_arbiter: vector table plus hand-written reset, pacing and preemption sequences.
module tb_xmit_arbiter;

  logic        clock = 1'b0;
  logic        extReset = 1'b1;
  logic        sample_write = 1'b0;
  logic [31:0] sample_data = '0;
  logic [3:0]  disabledGroups = '0;
  logic        sample_idle;
  logic        meta_write = 1'b0;
  logic [7:0]  meta_byte = '0;
  logic        meta_idle;
  logic        tx_busy;
  logic        tx_write;
  logic [7:0]  tx_byte;
  logic        xmit_idle;
`ifdef XMIT_QUERY_ID_EN
  logic        query_id = 1'b0;
`endif

  always #5 clock = ~clock;

  xmit_arbiter #(.GAP_CYCLES(1)) dut (
    .clock(clock),
    .extReset(extReset),
    .sample_write(sample_write),
    .sample_data(sample_data),
    .disabledGroups(disabledGroups),
    .sample_idle(sample_idle),
    .meta_write(meta_write),
    .meta_byte(meta_byte),
    .meta_idle(meta_idle),
`ifdef XMIT_QUERY_ID_EN
    .query_id(query_id),
`endif
    .tx_busy(tx_busy),
    .tx_write(tx_write),
    .tx_byte(tx_byte),
    .xmit_idle(xmit_idle)
  );

  int         cyc = 0;
  int         busy_cnt = 0;
  bit         busy_en = 1'b1;
  logic [7:0] log_byte[$];
  int         log_cyc[$];
  int         tests = 0;
  int         fails = 0;

  // Transmitter stand-in: busy for 3 cycles after each byte load.
  always @(posedge clock) begin
    if (tx_write) begin
      log_byte.push_back(tx_byte);
      log_cyc.push_back(cyc);
    end
    cyc <= cyc + 1;
    if (tx_write)           busy_cnt <= 3;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = busy_en && (busy_cnt != 0);

  typedef struct {
    bit          do_s;
    logic [31:0] data;
    logic [3:0]  dis;
    bit          do_m;
    logic [7:0]  mb;
    int          n;
    logic [63:0] exp;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic wait_log(input int n, input bit need_idle, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clock);
      if (log_byte.size() >= n && (!need_idle || xmit_idle)) ok = 1'b1;
    end
  endtask

  task automatic clear_log();
    log_byte.delete();
    log_cyc.delete();
  endtask

  task automatic post_sample(input logic [31:0] d, input logic [3:0] dis);
    sample_write   = 1'b1;
    sample_data    = d;
    disabledGroups = dis;
    @(negedge clock);
    sample_write   = 1'b0;
  endtask

  task automatic check_bytes(input string tag, input int n, input logic [63:0] exp);
    logic [7:0] got;
    check({tag, "_count"}, 32'(log_byte.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      got = (i < log_byte.size()) ? log_byte[i] : 8'h00;
      check($sformatf("%s_byte%0d", tag, i), 32'(got), 32'(exp[8*i +: 8]));
    end
  endtask

  initial begin
    bit ok;
    int scyc;
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    int scyc;

    vecs[0] = '{1'b1, 32'h44332211, 4'b0000, 1'b0, 8'h00, 4, 64'h0000_0000_4433_2211};
    vecs[1] = '{1'b1, 32'hDDCCBBAA, 4'b1010, 1'b0, 8'h00, 2, 64'h0000_0000_0000_CCAA};
    vecs[2] = '{1'b1, 32'hDDCCBBAA, 4'b1111, 1'b0, 8'h00, 0, 64'h0};
    vecs[3] = '{1'b1, 32'h44332211, 4'b0000, 1'b1, 8'h01, 5, 64'h0000_0044_3322_1101};
    vecs[4] = '{1'b0, 32'h00000000, 4'b0000, 1'b1, 8'h5A, 1, 64'h0000_0000_0000_005A};
    vecs[5] = '{1'b1, 32'h87654321, 4'b0000, 1'b1, 8'h7E, 5, 64'h0000_007E_8765_4321};
    vecs[6] = '{1'b1, 32'hA1B2C3D4, 4'b0110, 1'b0, 8'h00, 2, 64'h0000_0000_0000_A1D4};

    // Reset state
    repeat (2) @(negedge clock);
    extReset = 1'b0;
    check("rst_tx_write",    32'(tx_write),    32'd0);
    check("rst_tx_byte",     32'(tx_byte),     32'd0);
    check("rst_sample_idle", 32'(sample_idle), 32'd1);
    check("rst_meta_idle",   32'(meta_idle),   32'd1);
    check("rst_xmit_idle",   32'(xmit_idle),   32'd1);

    // Table of single-shot postings from a quiet arbiter
    for (int v = 0; v < NV; v++) begin
      wait_log(0, 1'b1, 100, ok);
      check($sformatf("v%0d_pre_idle", v), 32'(ok), 32'd1);
      clear_log();
      sample_write   = vecs[v].do_s;
      sample_data    = vecs[v].data;
      disabledGroups = vecs[v].dis;
      meta_write     = vecs[v].do_m;
      meta_byte      = vecs[v].mb;
      scyc           = cyc;
      @(negedge clock);
      sample_write = 1'b0;
      meta_write   = 1'b0;
      wait_log(vecs[v].n, 1'b1, 300, ok);
      check($sformatf("v%0d_done", v), 32'(ok), 32'd1);
      repeat (8) @(negedge clock);
      check_bytes($sformatf("v%0d", v), vecs[v].n, vecs[v].exp);
      if (vecs[v].n > 0 && log_cyc.size() > 0)
        check($sformatf("v%0d_latency", v), 32'(log_cyc[0] - scyc), 32'd2);
      check($sformatf("v%0d_sample_idle", v), 32'(sample_idle), 32'd1);
      check($sformatf("v%0d_meta_idle", v),   32'(meta_idle),   32'd1);
    end

    // Fully masked word: slot frees two cycles after the strobe, nothing sent
    clear_log();
    sample_write = 1'b1; sample_data = 32'h12345678; disabledGroups = 4'b1111;
    @(negedge clock);
    sample_write = 1'b0;
    check("mask_all_idle_n1", 32'(sample_idle), 32'd0);
    @(negedge clock);
    check("mask_all_idle_n2", 32'(sample_idle), 32'd1);
    repeat (5) @(negedge clock);
    check("mask_all_no_tx", 32'(log_byte.size()), 32'd0);

    // Minimum pacing with the transmitter never busy
    busy_en = 1'b0;
    clear_log();
    post_sample(32'h44332211, 4'b0000);
    wait_log(4, 1'b1, 200, ok);
    check("space_done", 32'(ok), 32'd1);
    for (int i = 0; i < 3; i++)
      if (i + 1 < log_cyc.size())
        check($sformatf("space_%0d", i), 32'(log_cyc[i+1] - log_cyc[i]), 32'd3);
    busy_en = 1'b1;
    repeat (6) @(negedge clock);

    // Meta posted mid-word waits for the whole word; a second meta strobe is dropped
    clear_log();
    post_sample(32'h44332211, 4'b0000);
    wait_log(2, 1'b0, 200, ok);
    check("mid_second_byte", 32'(ok), 32'd1);
    check("mid_meta_idle_before", 32'(meta_idle), 32'd1);
    meta_write = 1'b1; meta_byte = 8'hA5;
    @(negedge clock);
    check("mid_meta_idle_after", 32'(meta_idle), 32'd0);
    meta_byte = 8'h3C;
    @(negedge clock);
    meta_write = 1'b0;
    wait_log(5, 1'b1, 300, ok);
    check("mid_done", 32'(ok), 32'd1);
    repeat (15) @(negedge clock);
    check_bytes("mid", 5, 64'h0000_00A5_4433_2211);

    // Reset while waiting on the transmitter after byte 2
    clear_log();
    post_sample(32'h44332211, 4'b0000);
    wait_log(2, 1'b0, 200, ok);
    check("rst6_second_byte", 32'(ok), 32'd1);
    @(negedge clock);
    check("rst6_busy_held", 32'(tx_busy), 32'd1);
    extReset = 1'b1;
    @(negedge clock);
    extReset = 1'b0;
    check("rst6_tx_write",    32'(tx_write),    32'd0);
    check("rst6_tx_byte",     32'(tx_byte),     32'd0);
    repeat (20) @(negedge clock);
    check("rst6_no_more_tx",  32'(log_byte.size()), 32'd2);
    check("rst6_sample_idle", 32'(sample_idle), 32'd1);
    check("rst6_meta_idle",   32'(meta_idle),   32'd1);
    check("rst6_xmit_idle",   32'(xmit_idle),   32'd1);

`ifdef XMIT_QUERY_ID_EN
    // ID string takes priority over a sample word posted in the same cycle
    clear_log();
    query_id = 1'b1;
    post_sample(32'h44332211, 4'b0000);
    query_id = 1'b0;
    wait_log(8, 1'b1, 400, ok);
    check("qid_done", 32'(ok), 32'd1);
    repeat (8) @(negedge clock);
    check_bytes("qid", 8, 64'h4433_2211_534C_4131);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
